// File: rtl/cpu_ctrl_pkg.sv
// Shared control-bundle field positions, bubble encodings and widths used by the
// opcode decoder and the ID/EX pipeline register.
package cpu_ctrl_pkg;

  localparam int CTRL_W   = 5;
  localparam int OPCODE_W = 4;

  // EX bundle: {ALUOP[2:0], MemRead, MemWrite}
  localparam int EX_ALUOP_MSB = 4;
  localparam int EX_ALUOP_LSB = 2;
  localparam int EX_MEMREAD   = 1;
  localparam int EX_MEMWRITE  = 0;

  // MEM bundle: {RegWrite, MemToReg, PCtoReg, Branch, Jump}
  localparam int MEM_REGWRITE = 4;
  localparam int MEM_MEMTOREG = 3;
  localparam int MEM_PCTOREG  = 2;
  localparam int MEM_BRANCH   = 1;
  localparam int MEM_JUMP     = 0;

  localparam logic [CTRL_W-1:0] BUBBLE_EX  = 5'b00000;
  localparam logic [CTRL_W-1:0] BUBBLE_MEM = 5'b00000;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection against the ID/EX register contents, and the
// combined upstream stall request.
module hazard_detect #(
  parameter int REG_ADDR_W = 6
) (
  input  logic                  ValidOut,
  input  logic                  MemRead,
  input  logic [REG_ADDR_W-1:0] RdOut,
  input  logic [REG_ADDR_W-1:0] RsIn,
  input  logic [REG_ADDR_W-1:0] RtIn,
  input  logic                  ValidIn,
  input  logic                  ExtStall,
  input  logic                  Flush,
  output logic                  LoadUse,
  output logic                  Stall
);

  // Address 0 is an ordinary register here, so no zero-register exemption.
  assign LoadUse = ValidOut & MemRead & ValidIn & ((RdOut == RsIn) | (RdOut == RtIn));

  // A flushed decode slot is dead, so its hazard need not hold the front end.
  assign Stall = ExtStall | (LoadUse & ~Flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoder control bundles and operands, inserts
// bubbles on flush or load-use, freezes on external hold, counts bubbles.
module id_ex_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 6,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ValidIn,
  input  logic [CTRL_W-1:0]     EXIn,
  input  logic [CTRL_W-1:0]     MEMIn,
  input  logic [DATA_W-1:0]     PCIn,
  input  logic [DATA_W-1:0]     RsDataIn,
  input  logic [DATA_W-1:0]     RtDataIn,
  input  logic [REG_ADDR_W-1:0] RsIn,
  input  logic [REG_ADDR_W-1:0] RtIn,
  input  logic [REG_ADDR_W-1:0] RdIn,
  input  logic                  Flush,
  input  logic                  ExtStall,
  output logic [CTRL_W-1:0]     EXOut,
  output logic [CTRL_W-1:0]     MEMOut,
  output logic [DATA_W-1:0]     PCOut,
  output logic [DATA_W-1:0]     RsDataOut,
  output logic [DATA_W-1:0]     RtDataOut,
  output logic [REG_ADDR_W-1:0] RdOut,
  output logic                  ValidOut,
  output logic                  Stall,
  output logic [CNT_W-1:0]      BubbleCount
);

  logic load_use;
  logic load_bubble;
  logic count_bubble;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .ValidOut (ValidOut),
    .MemRead  (EXOut[EX_MEMREAD]),
    .RdOut    (RdOut),
    .RsIn     (RsIn),
    .RtIn     (RtIn),
    .ValidIn  (ValidIn),
    .ExtStall (ExtStall),
    .Flush    (Flush),
    .LoadUse  (load_use),
    .Stall    (Stall)
  );

  assign load_bubble  = Flush | load_use;
  // Flushing an empty slot inserts nothing new, so it is not counted.
  assign count_bubble = Flush ? ValidIn : load_use;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EXOut       <= BUBBLE_EX;
      MEMOut      <= BUBBLE_MEM;
      PCOut       <= '0;
      RsDataOut   <= '0;
      RtDataOut   <= '0;
      RdOut       <= '0;
      ValidOut    <= 1'b0;
      BubbleCount <= '0;
    end else if (!ExtStall) begin
      PCOut     <= PCIn;
      RsDataOut <= RsDataIn;
      RtDataOut <= RtDataIn;
      RdOut     <= RdIn;
      if (load_bubble || !ValidIn) begin
        EXOut    <= BUBBLE_EX;
        MEMOut   <= BUBBLE_MEM;
        ValidOut <= 1'b0;
      end else begin
        EXOut    <= EXIn;
        MEMOut   <= MEMIn;
        ValidOut <= 1'b1;
      end
      if (count_bubble && (BubbleCount != {CNT_W{1'b1}}))
        BubbleCount <= BubbleCount + CNT_W'(1);
    end
  end

endmodule
